// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: job, operand-feed, array and result signals of the systolic sequencer.
// master = controller side, slave = array/buffer/consumer side.
interface systolic_ctrl_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_LENGTH = 64,
  parameter int unsigned NUM_UNITS  = 64
);
  localparam int unsigned LW = $clog2(MAX_LENGTH);
  localparam int unsigned RW = $clog2(NUM_UNITS + 1);
  localparam int unsigned IW = $clog2(NUM_UNITS);

  logic                       job_valid;
  logic                       job_ready;
  logic [RW-1:0]              job_rows;
  logic [LW-1:0]              job_length;
  logic                       elem_valid;
  logic [LW-1:0]              elem_idx;
  logic                       arr_start;
  logic [NUM_UNITS-1:0]       arr_active_units;
  logic [LW-1:0]              arr_length;
  logic [NUM_UNITS-1:0]       arr_done;
  logic [NUM_UNITS*WIDTH-1:0] arr_result;
  logic                       res_valid;
  logic                       res_ready;
  logic [WIDTH-1:0]           res_data;
  logic [IW-1:0]              res_index;
  logic                       res_last;
  logic                       busy;
  logic                       err;

  modport master (
    input  job_valid, job_rows, job_length, arr_done, arr_result, res_ready,
    output job_ready, elem_valid, elem_idx, arr_start, arr_active_units, arr_length,
           res_valid, res_data, res_index, res_last, busy, err
  );

  modport slave (
    output job_valid, job_rows, job_length, arr_done, arr_result, res_ready,
    input  job_ready, elem_valid, elem_idx, arr_start, arr_active_units, arr_length,
           res_valid, res_data, res_index, res_last, busy, err
  );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: one-job-at-a-time sequencer for the dot-unit systolic array.
// Define SYSCTRL_WDOG_EN to add the WAIT watchdog and sticky err flag.
module systolic_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MAX_LENGTH  = 64,
  parameter int unsigned NUM_UNITS   = 64,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input logic             clk,
  input logic             reset,
  systolic_ctrl_if.master bus
);
  localparam int unsigned LW = $clog2(MAX_LENGTH);
  localparam int unsigned RW = $clog2(NUM_UNITS + 1);
  localparam int unsigned IW = $clog2(NUM_UNITS);

  typedef enum logic [2:0] {StIdle, StStart, StFeed, StWait, StDrain} state_e;

  state_e                     state_q, state_d;
  logic [RW-1:0]              rows_q, rows_d, rows_clamp;
  logic [LW-1:0]              len_q, len_d;
  logic [LW-1:0]              elem_q, elem_d;
  logic [IW-1:0]              res_q, res_d;
  logic [NUM_UNITS-1:0]       mask_q, mask_d;
  logic [NUM_UNITS*WIDTH-1:0] snap_q, snap_d;
  logic                       active, draining, all_done, last_res;
`ifdef SYSCTRL_WDOG_EN
  localparam int unsigned DW = $clog2(WDOG_CYCLES + 1);
  logic [DW-1:0]              wdog_q, wdog_d;
  logic                       err_q, err_d;
`endif

  assign rows_clamp = (bus.job_rows > RW'(NUM_UNITS)) ? RW'(NUM_UNITS) : bus.job_rows;
  // Done bits of inactive units are masked off.
  assign all_done   = (bus.arr_done & mask_q) == mask_q;
  assign last_res   = RW'(res_q) == (rows_q - RW'(1));
  assign active     = state_q != StIdle;
  assign draining   = state_q == StDrain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rows_q  <= '0;
      len_q   <= '0;
      elem_q  <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      snap_q  <= '0;
`ifdef SYSCTRL_WDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      len_q   <= len_d;
      elem_q  <= elem_d;
      res_q   <= res_d;
      mask_q  <= mask_d;
      snap_q  <= snap_d;
`ifdef SYSCTRL_WDOG_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    rows_d         = rows_q;
    len_d          = len_q;
    elem_d         = elem_q;
    res_d          = res_q;
    mask_d         = mask_q;
    snap_d         = snap_q;
`ifdef SYSCTRL_WDOG_EN
    wdog_d         = wdog_q;
    err_d          = err_q;
`endif
    bus.job_ready  = 1'b0;
    bus.arr_start  = 1'b0;
    bus.elem_valid = 1'b0;
    bus.res_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.job_ready = 1'b1;
        if (bus.job_valid) begin
          rows_d = rows_clamp;
          len_d  = bus.job_length;
          elem_d = '0;
          res_d  = '0;
          for (int i = 0; i < int'(NUM_UNITS); i++) begin
            mask_d[i] = i < int'(rows_clamp);
          end
`ifdef SYSCTRL_WDOG_EN
          err_d = 1'b0;
`endif
          // Empty jobs are consumed without touching the array.
          if (rows_clamp != '0 && bus.job_length != '0) begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        bus.arr_start = 1'b1;
        state_d       = StFeed;
      end
      StFeed: begin
        bus.elem_valid = 1'b1;
        if (elem_q == (len_q - LW'(1))) begin
          state_d = StWait;
`ifdef SYSCTRL_WDOG_EN
          wdog_d  = '0;
`endif
        end else begin
          elem_d = elem_q + LW'(1);
        end
      end
      StWait: begin
        if (all_done) begin
          snap_d  = bus.arr_result;
          res_d   = '0;
          state_d = StDrain;
`ifdef SYSCTRL_WDOG_EN
        end else if (wdog_q == DW'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + DW'(1);
`endif
        end
      end
      StDrain: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          if (last_res) begin
            state_d = StIdle;
          end else begin
            res_d = res_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy             = active;
  assign bus.arr_active_units = active ? mask_q : '0;
  assign bus.arr_length       = active ? len_q : '0;
  assign bus.elem_idx         = (state_q == StFeed) ? elem_q : '0;
  assign bus.res_index        = draining ? res_q : '0;
  assign bus.res_data         = draining ? snap_q[int'(res_q) * WIDTH +: WIDTH] : '0;
  assign bus.res_last         = draining && last_res;
`ifdef SYSCTRL_WDOG_EN
  assign bus.err              = err_q;
`else
  assign bus.err              = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: table-driven and randomized job checks for systolic_ctrl.
// Define SYSCTRL_WDOG_EN to build with a 16-cycle watchdog and run its abort sequence.
module tb_systolic_ctrl;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned MAXL  = 64;
  localparam int unsigned NU    = 64;
  localparam int unsigned RW    = $clog2(NU + 1);
  localparam int unsigned LW    = $clog2(MAXL);
`ifdef SYSCTRL_WDOG_EN
  localparam int unsigned WDOG      = 16;
  localparam int          MAX_DELAY = 12;
`else
  localparam int unsigned WDOG      = 1024;
  localparam int          MAX_DELAY = 20;
`endif

  typedef struct {
    int          rows;
    int          len;
    logic [63:0] mask;
    int          nres;
    int          delay;
    int          rdy;
  } vec_t;

  logic             clk;
  logic             reset;
  int               checks;
  int               failures;
  logic [WIDTH-1:0] exp_res [NU];
  bit               rdy_pat [5];
  vec_t             vecs [8];

  systolic_ctrl_if #(.WIDTH(WIDTH), .MAX_LENGTH(MAXL), .NUM_UNITS(NU)) bus ();

  systolic_ctrl #(
    .WIDTH      (WIDTH),
    .MAX_LENGTH (MAXL),
    .NUM_UNITS  (NU),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One whole job: handshake, start, feed, wait, drain, with expectations from the caller.
  task automatic run_job(input int rows, input int len, input logic [63:0] emask,
                         input int nres, input int delay, input int rdy);
    int idx;
    int cyc;
    bit rr;
    chk("accept_ready", bus.job_ready, 1);
    bus.job_valid  = 1'b1;
    bus.job_rows   = RW'(rows);
    bus.job_length = LW'(len);
    next_cycle();
    bus.job_valid  = 1'b0;
    bus.job_rows   = RW'($urandom);
    bus.job_length = LW'($urandom);
    chk("err_cleared", bus.err, 0);
    if (nres == 0) begin
      chk("discard_start", bus.arr_start, 0);
      chk("discard_busy", bus.busy, 0);
      chk("discard_ready", bus.job_ready, 1);
      chk("discard_mask", bus.arr_active_units, 0);
      return;
    end
    chk("start_pulse", bus.arr_start, 1);
    chk("start_mask", bus.arr_active_units, emask);
    chk("start_length", bus.arr_length, 64'(len));
    chk("start_not_ready", bus.job_ready, 0);
    chk("start_busy", bus.busy, 1);
    bus.arr_done = '1;
    for (int k = 0; k < len; k++) begin
      next_cycle();
      chk("feed_valid", bus.elem_valid, 1);
      chk("feed_idx", bus.elem_idx, 64'(k));
      chk("feed_no_start", bus.arr_start, 0);
    end
    next_cycle();
    bus.arr_done = ~emask | (emask >> 1);
    for (int d = 0; d < delay; d++) begin
      chk("wait_no_res", bus.res_valid, 0);
      chk("wait_no_elem", bus.elem_valid, 0);
      chk("wait_mask", bus.arr_active_units, emask);
      next_cycle();
    end
    bus.arr_done = emask | (~emask & {$urandom, $urandom});
    for (int i = 0; i < int'(NU * WIDTH / 32); i++) bus.arr_result[i*32 +: 32] = $urandom;
    for (int u = 0; u < int'(NU); u++) exp_res[u] = bus.arr_result[u*WIDTH +: WIDTH];
    chk("wait_no_res", bus.res_valid, 0);
    next_cycle();
    bus.arr_done = '0;
    for (int i = 0; i < int'(NU * WIDTH / 32); i++) bus.arr_result[i*32 +: 32] = $urandom;
    idx = 0;
    cyc = 0;
    while (idx < nres && cyc < nres * 20 + 50) begin
      rr = (rdy < 0) ? rdy_pat[cyc % 5] : (int'($urandom_range(99)) < rdy);
      bus.res_ready = rr;
      chk("drain_valid", bus.res_valid, 1);
      chk("drain_index", bus.res_index, 64'(idx));
      chk("drain_data", bus.res_data, 64'(exp_res[idx]));
      chk("drain_last", bus.res_last, (idx == nres - 1) ? 64'd1 : 64'd0);
      chk("drain_length", bus.arr_length, 64'(len));
      next_cycle();
      if (rr) idx++;
      cyc++;
    end
    bus.res_ready = 1'b0;
    chk("drain_count", 64'(idx), 64'(nres));
    chk("end_busy", bus.busy, 0);
    chk("end_ready", bus.job_ready, 1);
    chk("end_no_res", bus.res_valid, 0);
    chk("end_mask", bus.arr_active_units, 0);
    chk("end_err", bus.err, 0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rdy_pat        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[0] = '{rows: 3,   len: 4,  mask: 64'h7,       nres: 3,  delay: 0,         rdy: 100};
    vecs[1] = '{rows: 3,   len: 4,  mask: 64'h7,       nres: 3,  delay: 2,         rdy: -1};
    vecs[2] = '{rows: 2,   len: 3,  mask: 64'h3,       nres: 2,  delay: MAX_DELAY, rdy: 100};
    vecs[3] = '{rows: 0,   len: 5,  mask: 64'h0,       nres: 0,  delay: 0,         rdy: 100};
    vecs[4] = '{rows: 5,   len: 0,  mask: 64'h0,       nres: 0,  delay: 0,         rdy: 100};
    vecs[5] = '{rows: 64,  len: 2,  mask: {64{1'b1}},  nres: 64, delay: 1,         rdy: 70};
    vecs[6] = '{rows: 100, len: 1,  mask: {64{1'b1}},  nres: 64, delay: 0,         rdy: 100};
    vecs[7] = '{rows: 1,   len: 63, mask: 64'h1,       nres: 1,  delay: 3,         rdy: 50};
    bus.job_valid  = 1'b0;
    bus.job_rows   = '0;
    bus.job_length = '0;
    bus.arr_done   = '0;
    bus.arr_result = '0;
    bus.res_ready  = 1'b0;
    reset          = 1'b0;
    #2 reset = 1'b1;
    #2;
    chk("rst_job_ready", bus.job_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.arr_start, 0);
    chk("rst_elem_valid", bus.elem_valid, 0);
    chk("rst_elem_idx", bus.elem_idx, 0);
    chk("rst_mask", bus.arr_active_units, 0);
    chk("rst_length", bus.arr_length, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_index", bus.res_index, 0);
    chk("rst_res_last", bus.res_last, 0);
    chk("rst_err", bus.err, 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    for (int v = 0; v < 8; v++) begin
      run_job(vecs[v].rows, vecs[v].len, vecs[v].mask, vecs[v].nres, vecs[v].delay,
              vecs[v].rdy);
      next_cycle();
    end

    // Reset in the middle of FEED.
    bus.job_valid  = 1'b1;
    bus.job_rows   = RW'(3);
    bus.job_length = LW'(10);
    next_cycle();
    bus.job_valid = 1'b0;
    next_cycle();
    next_cycle();
    chk("pre_reset_feed", bus.elem_valid, 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_mask", bus.arr_active_units, 0);
    chk("midrst_elem", bus.elem_valid, 0);
    chk("midrst_ready", bus.job_ready, 1);
    next_cycle();
    reset = 1'b0;
    bus.arr_done = '1;
    for (int c = 0; c < 6; c++) begin
      chk("postrst_no_res", bus.res_valid, 0);
      chk("postrst_idle", bus.busy, 0);
      next_cycle();
    end
    bus.arr_done = '0;

`ifdef SYSCTRL_WDOG_EN
    bus.job_valid  = 1'b1;
    bus.job_rows   = RW'(2);
    bus.job_length = LW'(2);
    next_cycle();
    bus.job_valid = 1'b0;
    next_cycle();
    next_cycle();
    for (int w = 0; w < int'(WDOG); w++) begin
      next_cycle();
      chk("wdog_wait_busy", bus.busy, 1);
      chk("wdog_no_res", bus.res_valid, 0);
      chk("wdog_err_low", bus.err, 0);
    end
    next_cycle();
    chk("wdog_err_set", bus.err, 1);
    chk("wdog_idle", bus.busy, 0);
    chk("wdog_ready", bus.job_ready, 1);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      chk("wdog_no_res_after", bus.res_valid, 0);
      chk("wdog_err_sticky", bus.err, 1);
    end
    run_job(0, 5, 64'h0, 0, 0, 100);
    next_cycle();
`endif

    for (int j = 0; j < 25; j++) begin
      int          r;
      int          l;
      int          eff;
      int          nr;
      logic [63:0] m;
      r   = int'($urandom_range(80));
      l   = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(63));
      eff = (r > int'(NU)) ? int'(NU) : r;
      m   = (eff >= 64) ? {64{1'b1}} : ((64'd1 << eff) - 64'd1);
      nr  = (eff == 0 || l == 0) ? 0 : eff;
      run_job(r, l, m, nr, int'($urandom_range(MAX_DELAY)), int'($urandom_range(100, 30)));
      if ($urandom_range(3) == 0) next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Job sequencer for the dot-unit systolic array. It accepts one job at a time (row count, vector length) over a valid/ready handshake and drives the array's start, active-unit mask and length. It sequences the operand element index to the operand buffers, waits for every active unit's done, snapshots the results, then streams them out one per handshake.

Parameters:
WIDTH, 16, operand/result width
MAX_LENGTH, 64, vector length bound; length fields are $clog2(MAX_LENGTH) bits
NUM_UNITS, 64, dot units in the array
WDOG_CYCLES, 1024, watchdog limit in WAIT (used only with SYSCTRL_WDOG_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
job_valid  in  1  job request
job_ready  out  1  controller can accept a job
job_rows  in  $clog2(NUM_UNITS+1)  number of active units, from unit 0 upward
job_length  in  $clog2(MAX_LENGTH)  elements per dot product
elem_valid  out  1  operand buffers must present element elem_idx to all active units this cycle
elem_idx  out  $clog2(MAX_LENGTH)  element index being fed
arr_start  out  1  start pulse to the array
arr_active_units  out  NUM_UNITS  active-unit mask
arr_length  out  $clog2(MAX_LENGTH)  length, broadcast to all units
arr_done  in  NUM_UNITS  per-unit done from the array
arr_result  in  NUM_UNITS*WIDTH  per-unit results, packed
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
res_data  out  WIDTH  result of unit res_index
res_index  out  $clog2(NUM_UNITS)  unit number of res_data
res_last  out  1  final result of the job
busy  out  1  state != IDLE
err  out  1  sticky watchdog abort flag

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0 except job_ready=1. A reset mid-job aborts the job with no results. Result snapshot register is cleared.
- IDLE: job_ready=1.
  - On job_valid&job_ready: latch rows = min(job_rows, NUM_UNITS), latch length, mask = (1<<rows)-1, clear err, go to START.
  - If rows==0 or length==0: job is accepted and discarded, no array activity, stay IDLE.
- START (1 cycle): arr_start=1, go to FEED.
  - arr_active_units=mask and arr_length=latched length are held from START through DRAIN; both are 0 in IDLE.
- FEED: elem_valid=1, elem_idx counts 0..length-1 (one element per cycle, no stalls). After idx=length-1, go to WAIT.
- WAIT: when (arr_done & mask)==mask, register arr_result into the snapshot and go to DRAIN.
  - Done bits of inactive units are ignored.
  - The array clears done on start, so done is sampled only in WAIT.
- DRAIN: res_valid=1, res_index counts 0..rows-1, res_data = snapshot[res_index], res_last = (res_index==rows-1).
  - Outputs stay stable while res_valid & !res_ready.
  - Index advances on each handshake; the handshake with res_last set returns to IDLE.
- Timing: job accepted in cycle T → arr_start at T+1; elem_valid T+2..T+1+length; earliest WAIT exit at T+2+length; first res_valid the cycle after the WAIT exit.
- job_ready=0 in every non-IDLE state. Once a job is accepted, job_* inputs are not sampled again until the job completes.
- Counters are sized for MAX_LENGTH-1 and NUM_UNITS-1 with no wrap; the terminal value is compared before any increment.

Optional Feature:
SYSCTRL_WDOG_EN
- Defined: a counter cleared on WAIT entry increments each WAIT cycle. On reaching WDOG_CYCLES without all masked done bits: err=1 (sticky until the next accepted job), return to IDLE with no results emitted.
- Undefined: WAIT waits indefinitely; err tied to 0.

Test Plan:
- Reset asserted mid-FEED → next cycle state IDLE, arr_active_units=0, elem_valid=0, job_ready=1, no res_valid afterwards.
- Job rows=3, length=4 → arr_start one cycle at T+1 with mask 0x7 and arr_length=4; elem_idx 0,1,2,3 at T+2..T+5; after arr_done[2:0]=111, res_index 0,1,2 with matching arr_result slices and res_last on index 2.
- Same job with res_ready toggling 1,0,0,1,1 → each result held stable while stalled; exactly 3 handshakes; IDLE after the last.
- Job rows=2 with arr_done=0b01 for 20 cycles, then 0b11 (done of unit 5 held high throughout) → stays in WAIT until 0b11; unit 5 done ignored.
- Job rows=0 or length=0 → accepted (job_ready=1 at handshake), arr_start never asserted, busy stays 0.
- Build with SYSCTRL_WDOG_EN and WDOG_CYCLES=16, done never asserted → err=1 after 16 WAIT cycles, IDLE, no res_valid; next accepted job clears err.
